// File: rtl/all_gates_pkg.sv
// ----------------------------------------------------------------------------
// all_gates_pkg
//
// Shared definitions for the registered logic-gate unit.
//
// Contents:
//   op_t              3-bit result selector used by the optional y_sel view
//   OP_AND..OP_PASS_A named selector values 0..7
//   NUM_GATES         number of dedicated gate outputs (and..not)
//
// The selector only matters when ALL_GATES_SEL_EN is defined; the constants
// are always present so that benches and other blocks can refer to them.
// ----------------------------------------------------------------------------
package all_gates_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND    = 3'd0;
  localparam op_t OP_OR     = 3'd1;
  localparam op_t OP_NAND   = 3'd2;
  localparam op_t OP_NOR    = 3'd3;
  localparam op_t OP_XOR    = 3'd4;
  localparam op_t OP_XNOR   = 3'd5;
  localparam op_t OP_NOT    = 3'd6;
  localparam op_t OP_PASS_A = 3'd7;

  localparam int NUM_GATES = 7;

endpackage

// File: rtl/all_gates_comb.sv
// ----------------------------------------------------------------------------
// all_gates_comb
//
// Purely combinational half of the gate unit. Every result is formed bit by
// bit from a[i] and b[i]; there is no interaction between bit positions.
//
// Optional feature macro: ALL_GATES_SEL_EN (adds op input and y_sel output).
//
// Parameters:
//   WIDTH   operand / result width in bits (>= 1)
//
// Ports:
//   a       in  WIDTH  first operand, sole input of NOT and pass-through
//   b       in  WIDTH  second operand
//   y_and   out WIDTH  a & b
//   y_or    out WIDTH  a | b
//   y_nand  out WIDTH  ~(a & b)
//   y_nor   out WIDTH  ~(a | b)
//   y_xor   out WIDTH  a ^ b
//   y_xnor  out WIDTH  ~(a ^ b)
//   y_not   out WIDTH  ~a
//   op      in  3      result selector        (ALL_GATES_SEL_EN only)
//   y_sel   out WIDTH  result chosen by op     (ALL_GATES_SEL_EN only)
// ----------------------------------------------------------------------------
module all_gates_comb
  import all_gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_nand,
  output logic [WIDTH-1:0] y_nor,
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] y_xnor,
  output logic [WIDTH-1:0] y_not
`ifdef ALL_GATES_SEL_EN
  ,
  input  op_t              op,
  output logic [WIDTH-1:0] y_sel
`endif
);

  // The inverted gates are built from their base gate so the pairs can
  // never disagree with each other.
  always_comb begin
    y_and  = a & b;
    y_or   = a | b;
    y_xor  = a ^ b;
    y_nand = ~y_and;
    y_nor  = ~y_or;
    y_xnor = ~y_xor;
    y_not  = ~a;
  end

`ifdef ALL_GATES_SEL_EN
  // Selected view reuses the gate vectors above; b plays no part for
  // OP_NOT and OP_PASS_A.
  always_comb begin
    y_sel = '0;
    case (op)
      OP_AND:    y_sel = y_and;
      OP_OR:     y_sel = y_or;
      OP_NAND:   y_sel = y_nand;
      OP_NOR:    y_sel = y_nor;
      OP_XOR:    y_sel = y_xor;
      OP_XNOR:   y_sel = y_xnor;
      OP_NOT:    y_sel = y_not;
      OP_PASS_A: y_sel = a;
      default:   y_sel = '0;
    endcase
  end
`endif

endmodule

// File: rtl/all_gates.sv
// ----------------------------------------------------------------------------
// all_gates
//
// Registered bitwise logic-gate unit. Operands accepted on a rising clk edge
// with in_valid high appear on the y_* outputs one cycle later; with in_valid
// low the outputs hold. out_valid is a plain registered copy of in_valid.
// There is no combinational path from any input to any output.
//
// Optional feature macro: ALL_GATES_SEL_EN (adds op input and y_sel output,
// registered with the same timing and reset as the other results).
//
// Parameters:
//   WIDTH      operand / result width in bits (>= 1)
//
// Ports:
//   clk        in  1      rising-edge clock
//   rst        in  1      asynchronous active-high reset
//   in_valid   in  1      sample a/b (and op) on this edge
//   a          in  WIDTH  first operand
//   b          in  WIDTH  second operand
//   op         in  3      y_sel selector             (ALL_GATES_SEL_EN only)
//   y_and..y_not out WIDTH registered gate results
//   y_sel      out WIDTH  registered selected result (ALL_GATES_SEL_EN only)
//   out_valid  out 1      registered in_valid
// ----------------------------------------------------------------------------
module all_gates
  import all_gates_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef ALL_GATES_SEL_EN
  input  op_t              op,
  output logic [WIDTH-1:0] y_sel,
`endif
  output logic [WIDTH-1:0] y_and,
  output logic [WIDTH-1:0] y_or,
  output logic [WIDTH-1:0] y_nand,
  output logic [WIDTH-1:0] y_nor,
  output logic [WIDTH-1:0] y_xor,
  output logic [WIDTH-1:0] y_xnor,
  output logic [WIDTH-1:0] y_not,
  output logic             out_valid
);

  logic [WIDTH-1:0] c_and;
  logic [WIDTH-1:0] c_or;
  logic [WIDTH-1:0] c_nand;
  logic [WIDTH-1:0] c_nor;
  logic [WIDTH-1:0] c_xor;
  logic [WIDTH-1:0] c_xnor;
  logic [WIDTH-1:0] c_not;
`ifdef ALL_GATES_SEL_EN
  logic [WIDTH-1:0] c_sel;
`endif

  all_gates_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .a      (a),
    .b      (b),
    .y_and  (c_and),
    .y_or   (c_or),
    .y_nand (c_nand),
    .y_nor  (c_nor),
    .y_xor  (c_xor),
    .y_xnor (c_xnor),
    .y_not  (c_not)
`ifdef ALL_GATES_SEL_EN
    ,
    .op     (op),
    .y_sel  (c_sel)
`endif
  );

  // Result registers. Reset clears everything to 0, including the inverted
  // gates, so nothing looks like a gate result until the first accepted
  // operation. An edge during reset ignores in_valid entirely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_and     <= '0;
      y_or      <= '0;
      y_nand    <= '0;
      y_nor     <= '0;
      y_xor     <= '0;
      y_xnor    <= '0;
      y_not     <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        y_and  <= c_and;
        y_or   <= c_or;
        y_nand <= c_nand;
        y_nor  <= c_nor;
        y_xor  <= c_xor;
        y_xnor <= c_xnor;
        y_not  <= c_not;
      end
    end
  end

`ifdef ALL_GATES_SEL_EN
  // Selected result follows the same load/hold/reset rules as the gates.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_sel <= '0;
    end else if (in_valid) begin
      y_sel <= c_sel;
    end
  end
`endif

endmodule

// File: tb/tb_all_gates.sv
// ----------------------------------------------------------------------------
// tb_all_gates
//
// Self-checking bench for all_gates. Two instances run side by side, one at
// WIDTH=8 and one at WIDTH=1, sharing clock and reset. A bench-side model
// computes each result bit arithmetically from the operand bits and tracks
// the one-cycle latency, hold and reset behaviour; it is checked against
// both instances on every falling edge. Hand-computed literal vectors pin
// the model at the interesting points.
//
// Works with or without ALL_GATES_SEL_EN.
// ----------------------------------------------------------------------------
module tb_all_gates;
  import all_gates_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic       iv8;
  logic [7:0] a8, b8;
  op_t        op8;
  logic [7:0] y8_and, y8_or, y8_nand, y8_nor, y8_xor, y8_xnor, y8_not, y8_sel;
  logic       ov8;

  // WIDTH=1 instance
  logic       iv1;
  logic [0:0] a1, b1;
  op_t        op1;
  logic [0:0] y1_and, y1_or, y1_nand, y1_nor, y1_xor, y1_xnor, y1_not, y1_sel;
  logic       ov1;

  all_gates #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .a         (a8),
    .b         (b8),
`ifdef ALL_GATES_SEL_EN
    .op        (op8),
    .y_sel     (y8_sel),
`endif
    .y_and     (y8_and),
    .y_or      (y8_or),
    .y_nand    (y8_nand),
    .y_nor     (y8_nor),
    .y_xor     (y8_xor),
    .y_xnor    (y8_xnor),
    .y_not     (y8_not),
    .out_valid (ov8)
  );

  all_gates #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv1),
    .a         (a1),
    .b         (b1),
`ifdef ALL_GATES_SEL_EN
    .op        (op1),
    .y_sel     (y1_sel),
`endif
    .y_and     (y1_and),
    .y_or      (y1_or),
    .y_nand    (y1_nand),
    .y_nor     (y1_nor),
    .y_xor     (y1_xor),
    .y_xnor    (y1_xnor),
    .y_not     (y1_not),
    .out_valid (ov1)
  );

`ifndef ALL_GATES_SEL_EN
  assign y8_sel = '0;
  assign y1_sel = '0;
`endif

  // DUT outputs gathered in gate order: and, or, nand, nor, xor, xnor, not
  logic [7:0] d8 [0:6];
  logic [7:0] d1 [0:6];
  assign d8[0] = y8_and;  assign d8[1] = y8_or;   assign d8[2] = y8_nand;
  assign d8[3] = y8_nor;  assign d8[4] = y8_xor;  assign d8[5] = y8_xnor;
  assign d8[6] = y8_not;
  assign d1[0] = {7'd0, y1_and};  assign d1[1] = {7'd0, y1_or};
  assign d1[2] = {7'd0, y1_nand}; assign d1[3] = {7'd0, y1_nor};
  assign d1[4] = {7'd0, y1_xor};  assign d1[5] = {7'd0, y1_xnor};
  assign d1[6] = {7'd0, y1_not};

  string gname [0:7] = '{"and", "or", "nand", "nor", "xor", "xnor", "not", "sel"};

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Gate g per bit using arithmetic on 0/1 values: p = x*y, s = x+y.
  // g follows the op numbering: 0..6 gates, 7 pass-through a.
  function automatic logic [7:0] model_gate(input int g, input logic [7:0] x,
                                            input logic [7:0] y, input int w);
    logic [7:0] r;
    int xi, yi, s, p, v;
    r = '0;
    for (int i = 0; i < w; i++) begin
      xi = int'(x[i]);
      yi = int'(y[i]);
      s  = xi + yi;
      p  = xi * yi;
      case (g)
        0:       v = p;
        1:       v = s - p;
        2:       v = 1 - p;
        3:       v = 1 - (s - p);
        4:       v = s % 2;
        5:       v = 1 - (s % 2);
        6:       v = 1 - xi;
        default: v = xi;
      endcase
      r[i] = (v != 0);
    end
    return r;
  endfunction

  // Model state: what each output must read after the latest edge.
  logic [7:0] m8 [0:6];
  logic [7:0] m1 [0:6];
  logic [7:0] m8_sel, m1_sel;
  logic       m8_v, m1_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int g = 0; g < 7; g++) begin
        m8[g] = '0;
        m1[g] = '0;
      end
      m8_sel = '0; m1_sel = '0;
      m8_v   = 1'b0; m1_v = 1'b0;
    end else begin
      m8_v = iv8;
      m1_v = iv1;
      if (iv8) begin
        for (int g = 0; g < 7; g++) m8[g] = model_gate(g, a8, b8, 8);
        m8_sel = model_gate(int'(op8), a8, b8, 8);
      end
      if (iv1) begin
        for (int g = 0; g < 7; g++) m1[g] = model_gate(g, {7'd0, a1}, {7'd0, b1}, 1);
        m1_sel = model_gate(int'(op1), {7'd0, a1}, {7'd0, b1}, 1);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [7:0] act,
                             input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int g = 0; g < 7; g++) begin
        checkOutput({"model8_", gname[g]}, d8[g], m8[g]);
        checkOutput({"model1_", gname[g]}, d1[g], m1[g]);
      end
      checkOutput("model8_valid", {7'd0, ov8}, {7'd0, m8_v});
      checkOutput("model1_valid", {7'd0, ov1}, {7'd0, m1_v});
`ifdef ALL_GATES_SEL_EN
      checkOutput("model8_sel", y8_sel, m8_sel);
      checkOutput("model1_sel", {7'd0, y1_sel}, m1_sel);
`endif
    end
  end

  // Inputs change just after a falling edge, well away from the sampling edge.
  task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv,
                               input logic [2:0] opv, input logic v8,
                               input logic av1, input logic bv1, input logic v1);
    @(negedge clk);
    #1;
    a8 = av;  b8 = bv;  op8 = opv; iv8 = v8;
    a1 = av1; b1 = bv1; op1 = opv; iv1 = v1;
  endtask

  task automatic checkAllZero(input string tag);
    for (int g = 0; g < 7; g++) begin
      checkOutput({tag, "8_", gname[g]}, d8[g], 8'h00);
      checkOutput({tag, "1_", gname[g]}, d1[g], 8'h00);
    end
    checkOutput({tag, "8_valid"}, {7'd0, ov8}, 8'h00);
    checkOutput({tag, "1_valid"}, {7'd0, ov1}, 8'h00);
`ifdef ALL_GATES_SEL_EN
    checkOutput({tag, "8_sel"}, y8_sel, 8'h00);
`endif
  endtask

  logic [6:0] tt   [0:3];
  logic [7:0] lit8 [0:7];

  initial begin
    // Truth table rows for a,b = 00,01,10,11; bit 6 = and ... bit 0 = not
    tt   = '{7'b0011011, 7'b0110101, 7'b0110100, 7'b1100010};
    lit8 = '{8'hC0, 8'hFC, 8'h3F, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; op8 = OP_AND;
    iv1 = 1'b0; a1 = '0; b1 = '0; op1 = OP_AND;

    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset_");
    @(negedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;

    // Truth table on WIDTH=1 alongside F0/CC with op swept on WIDTH=8
    for (int s = 0; s < 8; s++) begin
      applyStimulus(8'hF0, 8'hCC, 3'(s), 1'b1, s[1], s[0], (s < 4));
      @(posedge clk);
      #1;
      for (int g = 0; g < 7; g++) begin
        checkOutput({"lit8_", gname[g]}, d8[g], lit8[g]);
        if (s < 4)
          checkOutput({"lit1_", gname[g]}, d1[g], {7'd0, tt[s][6-g]});
      end
      checkOutput("lit8_valid", {7'd0, ov8}, 8'h01);
`ifdef ALL_GATES_SEL_EN
      checkOutput("lit8_sel", y8_sel, lit8[s]);
`endif
    end

    // Hold: accepted 1,1 then unaccepted 0,0
    applyStimulus(8'h00, 8'h00, OP_AND, 1'b0, 1'b1, 1'b1, 1'b1);
    applyStimulus(8'h00, 8'h00, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("hold1_and", {7'd0, y1_and}, 8'h01);
    checkOutput("hold1_valid", {7'd0, ov1}, 8'h00);
    checkOutput("hold8_and", y8_and, 8'hC0);

    // Reset between edges with an operation in flight
    applyStimulus(8'hAA, 8'h55, OP_OR, 1'b1, 1'b1, 1'b0, 1'b1);
    #2 rst = 1'b1;
    #1;
    checkAllZero("async_");
    @(posedge clk);
    #1;
    checkAllZero("inrst_");
    @(negedge clk);
    #1;
    rst = 1'b0; iv8 = 1'b0; iv1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("postrst_");

    // Back-to-back traffic with occasional idle cycles
    for (int n = 0; n < 60; n++) begin
      applyStimulus(8'($urandom), 8'($urandom), 3'($urandom_range(7, 0)),
                    ($urandom_range(3, 0) != 0), 1'($urandom), 1'($urandom),
                    ($urandom_range(3, 0) != 0));
    end
    applyStimulus(8'h00, 8'h00, OP_AND, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
